// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared loader state encoding, fill modes and pipeline opcode/funct constants
package pipeline_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FILL = 3'd1,
    LOAD = 3'd2,
    HOLD = 3'd3,
    RUN  = 3'd4,
    DONE = 3'd5
  } loader_state_t;

  localparam int FILL_ZERO  = 0;
  localparam int FILL_INDEX = 1;

  // Primary opcodes of the five-stage pipeline
  localparam logic [5:0] R_TYPE     = 6'h00;
  localparam logic [5:0] LOAD_WORD  = 6'h23;
  localparam logic [5:0] STORE_WORD = 6'h2b;
  localparam logic [5:0] BRANCH_EQ  = 6'h04;
  localparam logic [5:0] JUMP       = 6'h02;

  // R-type funct field
  localparam logic [5:0] AND = 6'h24;
  localparam logic [5:0] OR  = 6'h25;
  localparam logic [5:0] ADD = 6'h20;
  localparam logic [5:0] SUB = 6'h22;
  localparam logic [5:0] SLT = 6'h2a;
  localparam logic [5:0] NOR = 6'h27;

endpackage

// File: rtl/pipeline_loader.sv
// rtl/pipeline_loader.sv - fills data memory, streams a program into instruction memory, then runs the pipeline
module pipeline_loader
  import pipeline_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int IMEM_AW    = 6,
  parameter int DMEM_AW    = 6,
  parameter int FILL_MODE  = 1,
  parameter int RST_HOLD   = 2,
  parameter int RUN_CYCLES = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [DATA_W-1:0]  s_data,
  input  logic               s_last,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [DATA_W-1:0]  imem_wdata,
  output logic               dmem_we,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  output logic               cpu_rst,
  output logic               busy,
  output logic               done,
  output logic               overflow
);

  localparam logic [IMEM_AW-1:0] IMEM_LAST = '1;
  localparam logic [DMEM_AW-1:0] DMEM_LAST = '1;
  localparam logic [31:0]        HOLD_LAST = 32'(RST_HOLD - 1);
  localparam logic [31:0]        RUN_LAST  = 32'(RUN_CYCLES - 1);

  loader_state_t      state;
  logic [IMEM_AW-1:0] word_cnt;
  logic [31:0]        hold_cnt;
  logic [31:0]        run_cnt;
  logic               accept;

  assign accept = (state == LOAD) && s_valid && s_ready;

  function automatic logic [DATA_W-1:0] fill_value(input logic [DMEM_AW-1:0] addr);
    if (FILL_MODE == FILL_INDEX) return DATA_W'(addr);
    return '0;
  endfunction

  // dmem_addr doubles as the fill counter; word_cnt tracks the next imem slot
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      word_cnt   <= '0;
      hold_cnt   <= '0;
      run_cnt    <= '0;
      s_ready    <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      cpu_rst    <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= FILL;
            busy       <= 1'b1;
            done       <= 1'b0;
            overflow   <= 1'b0;
            cpu_rst    <= 1'b1;
            word_cnt   <= '0;
            hold_cnt   <= '0;
            run_cnt    <= '0;
            dmem_we    <= 1'b1;
            dmem_addr  <= '0;
            dmem_wdata <= fill_value('0);
          end
        end
        FILL: begin
          if (dmem_addr == DMEM_LAST) begin
            state   <= LOAD;
            dmem_we <= 1'b0;
            s_ready <= 1'b1;
          end else begin
            dmem_addr  <= dmem_addr + 1'b1;
            dmem_wdata <= fill_value(dmem_addr + 1'b1);
          end
        end
        LOAD: begin
          if (accept) begin
            imem_we    <= 1'b1;
            imem_addr  <= word_cnt;
            imem_wdata <= s_data;
            // The top slot ends loading either way; only a missing s_last flags overflow
            if (s_last || word_cnt == IMEM_LAST) begin
              s_ready  <= 1'b0;
              overflow <= !s_last;
              if (RST_HOLD == 0) begin
                state   <= RUN;
                cpu_rst <= 1'b0;
              end else begin
                state <= HOLD;
              end
            end
            if (word_cnt != IMEM_LAST) word_cnt <= word_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state   <= RUN;
            cpu_rst <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        RUN: begin
          if (RUN_CYCLES != 0 && run_cnt == RUN_LAST) begin
            state   <= DONE;
            cpu_rst <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_loader.sv
// tb/tb_pipeline_loader.sv - directed/randomised bench for pipeline_loader against a memory-image model
module tb_pipeline_loader;

  localparam int NW   = 64;
  localparam int HOLD = 2;
  localparam int RUNC = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic [31:0] s_data = '0;

  logic        s_ready, imem_we, dmem_we, cpu_rst, busy, done, overflow;
  logic [5:0]  imem_addr, dmem_addr;
  logic [31:0] imem_wdata, dmem_wdata;

  logic        z_s_ready, z_imem_we, z_dmem_we, z_cpu_rst, z_busy, z_done, z_overflow;
  logic [5:0]  z_imem_addr, z_dmem_addr;
  logic [31:0] z_imem_wdata, z_dmem_wdata;

  pipeline_loader dut (
    .clk(clk), .rst(rst), .start(start),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .overflow(overflow)
  );

  pipeline_loader #(.FILL_MODE(0), .RUN_CYCLES(0)) dut_free (
    .clk(clk), .rst(rst), .start(start),
    .s_valid(s_valid), .s_ready(z_s_ready), .s_data(s_data), .s_last(s_last),
    .imem_we(z_imem_we), .imem_addr(z_imem_addr), .imem_wdata(z_imem_wdata),
    .dmem_we(z_dmem_we), .dmem_addr(z_dmem_addr), .dmem_wdata(z_dmem_wdata),
    .cpu_rst(z_cpu_rst), .busy(z_busy), .done(z_done), .overflow(z_overflow)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;

  // Memory images as the pipeline's inst_mem/data_mem would hold them
  logic [31:0] imem_obs  [NW];
  logic [31:0] dmem_obs  [NW];
  logic [31:0] dmem2_obs [NW];
  int imem_wr_cnt = 0;
  int dmem_wr_cnt = 0;
  int clash_cnt = 0;

  always @(posedge clk) begin
    if (imem_we) begin
      imem_obs[imem_addr] <= imem_wdata;
      imem_wr_cnt <= imem_wr_cnt + 1;
    end
    if (dmem_we) begin
      dmem_obs[dmem_addr] <= dmem_wdata;
      dmem_wr_cnt <= dmem_wr_cnt + 1;
    end
    if (z_dmem_we) dmem2_obs[z_dmem_addr] <= z_dmem_wdata;
    if ((imem_we && dmem_we) || (z_imem_we && z_dmem_we)) clash_cnt <= clash_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_fill(input bit chk_free);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_clears_done", done, 0);
    chk("start_clears_overflow", overflow, 0);
    chk("fill_busy", busy, 1);
    for (int i = 0; i < NW; i++) begin
      chk("fill_we", dmem_we, 1);
      chk("fill_addr", dmem_addr, i);
      chk("fill_data_index", dmem_wdata, i);
      chk("fill_no_imem", imem_we, 0);
      chk("fill_not_ready", s_ready, 0);
      if (chk_free) chk("fill_data_zero", z_dmem_wdata, 0);
      tick();
    end
    chk("load_ready", s_ready, 1);
    chk("fill_end_we", dmem_we, 0);
    if (chk_free) chk("load_ready_free", z_s_ready, 1);
  endtask

  task automatic send_word(input logic [31:0] d, input logic last, input int gap,
                           input int exp_addr, input int budget, output bit acc);
    s_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      tick();
      chk("gap_no_write", imem_we, 0);
    end
    s_data = d;
    s_last = last;
    s_valid = 1'b1;
    acc = 1'b0;
    for (int c = 0; c < budget && !acc; c++) begin
      if (s_ready) acc = 1'b1;
      tick();
    end
    s_valid = 1'b0;
    s_last = 1'b0;
    if (acc) begin
      chk("imem_we_next_cycle", imem_we, 1);
      chk("imem_addr", imem_addr, exp_addr);
      chk("imem_wdata", imem_wdata, d);
      chk("imem_dmem_exclusive", dmem_we, 0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    start = 1'b0;
    s_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  logic [31:0] prog [4];
  logic [31:0] model_q [$];
  bit acc;
  int base;
  int waited;
  logic [31:0] w;

  initial begin
    prog[0] = {6'h23, 5'd31, 5'd1, 16'd0};
    prog[1] = {6'h23, 5'd31, 5'd2, 16'd0};
    prog[2] = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20};
    prog[3] = {6'h2b, 5'd0, 5'd3, 16'd0};

    tick();
    tick();
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_imem_we", imem_we, 0);
    chk("rst_dmem_we", dmem_we, 0);
    rst = 1'b1;
    tick();
    chk("idle_cpu_rst", cpu_rst, 1);

    // Four-word program, fill pattern, hold and run budget
    run_fill(1'b1);
    for (int i = 0; i < 4; i++) begin
      send_word(prog[i], i == 3, 0, i, 20, acc);
      chk("prog_accepted", acc, 1);
    end
    chk("ready_drops_after_last", s_ready, 0);
    for (int h = 0; h < HOLD; h++) begin
      chk("hold_cpu_rst", cpu_rst, 1);
      chk("hold_busy", busy, 1);
      tick();
    end
    for (int k = 0; k < 100; k++) begin
      start = (k == 3);
      if (k < RUNC) begin
        chk("run_cpu_rst", cpu_rst, 0);
        chk("run_not_done", done, 0);
      end else begin
        chk("done_flag", done, 1);
        chk("done_cpu_rst", cpu_rst, 1);
        chk("done_not_busy", busy, 0);
      end
      chk("free_run_cpu_rst", z_cpu_rst, 0);
      chk("free_run_not_done", z_done, 0);
      chk("free_run_busy", z_busy, 1);
      tick();
    end
    start = 1'b0;
    for (int i = 0; i < 4; i++) chk("imem_image", imem_obs[i], prog[i]);
    for (int i = 0; i < NW; i++) begin
      chk("dmem_image_index", dmem_obs[i], i);
      chk("dmem_image_zero", dmem2_obs[i], 0);
    end
    chk("imem_write_count", imem_wr_cnt, 4);
    chk("dmem_write_count", dmem_wr_cnt, NW);

    // Restart from DONE, then overrun instruction memory
    run_fill(1'b0);
    base = imem_wr_cnt;
    model_q.delete();
    for (int i = 0; i <= NW; i++) begin
      w = $urandom;
      send_word(w, 1'b0, $urandom_range(0, 2), i, (i < NW) ? 20 : 6, acc);
      if (i < NW) begin
        chk("ovf_word_accepted", acc, 1);
        model_q.push_back(w);
      end else begin
        chk("ovf_word65_rejected", acc, 0);
      end
      if (i == NW - 1) begin
        chk("ovf_flag", overflow, 1);
        chk("ovf_ready_low", s_ready, 0);
      end
    end
    chk("ovf_write_count", imem_wr_cnt - base, NW);
    for (int i = 0; i < NW; i++) chk("ovf_imem_image", imem_obs[i], model_q[i]);
    waited = 0;
    while (!done && waited < 50) begin
      tick();
      waited++;
    end
    chk("ovf_reaches_done", done, 1);
    chk("ovf_flag_held", overflow, 1);

    // s_valid toggling every other cycle
    do_reset();
    run_fill(1'b1);
    base = imem_wr_cnt;
    model_q.delete();
    for (int i = 0; i < 6; i++) begin
      w = $urandom;
      send_word(w, i == 5, 1, i, 20, acc);
      chk("toggle_accepted", acc, 1);
      model_q.push_back(w);
    end
    tick();
    chk("toggle_write_count", imem_wr_cnt - base, 6);
    for (int i = 0; i < 6; i++) chk("toggle_imem_image", imem_obs[i], model_q[i]);

    // Reset in the middle of LOAD, then a single-word program
    do_reset();
    run_fill(1'b1);
    for (int i = 0; i < 2; i++) begin
      send_word($urandom, 1'b0, $urandom_range(0, 1), i, 20, acc);
      chk("pre_reset_accepted", acc, 1);
    end
    rst = 1'b0;
    tick();
    chk("midrst_cpu_rst", cpu_rst, 1);
    chk("midrst_s_ready", s_ready, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_imem_we", imem_we, 0);
    chk("midrst_dmem_we", dmem_we, 0);
    rst = 1'b1;
    tick();
    run_fill(1'b1);
    w = $urandom;
    send_word(w, 1'b1, 0, 0, 20, acc);
    chk("single_accepted", acc, 1);
    chk("single_ready_low", s_ready, 0);
    chk("single_no_overflow", overflow, 0);
    for (int h = 0; h < HOLD; h++) begin
      chk("single_hold_cpu_rst", cpu_rst, 1);
      tick();
    end
    chk("single_run_cpu_rst", cpu_rst, 0);
    tick();
    chk("single_imem0", imem_obs[0], w);
    chk("never_both_we", clash_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/pipeline_loader.md
PIPELINE_LOADER -- requirements
Module: pipeline_loader

Interface
REQ-001 SHALL have parameter DATA_W, default 32, instruction/data word width.
REQ-002 SHALL have parameter IMEM_AW, default 6, instruction memory address width (64 words).
REQ-003 SHALL have parameter DMEM_AW, default 6, data memory address width (64 words).
REQ-004 SHALL have parameter FILL_MODE, default 1: 0 fills data memory with zero, 1 fills it with the word index.
REQ-005 SHALL have parameter RST_HOLD, default 2, cycles the CPU reset is held after loading.
REQ-006 SHALL have parameter RUN_CYCLES, default 10, run budget in cycles; 0 means unlimited.
REQ-007 SHALL have ports, one per line:
  clk  in  1  single clock, all logic on rising edge
  rst  in  1  synchronous, active-low reset
  start  in  1  begin a load/run sequence
  s_valid  in  1  program word valid
  s_ready  out  1  loader accepts program word
  s_data  in  DATA_W  program word
  s_last  in  1  final program word
  imem_we  out  1  instruction memory write enable
  imem_addr  out  IMEM_AW  instruction memory word address
  imem_wdata  out  DATA_W  instruction memory write data
  dmem_we  out  1  data memory write enable
  dmem_addr  out  DMEM_AW  data memory word address
  dmem_wdata  out  DATA_W  data memory write data
  cpu_rst  out  1  active-high reset to the five-stage pipeline
  busy  out  1  sequence in progress (FILL, LOAD, HOLD, RUN)
  done  out  1  run budget expired
  overflow  out  1  program exceeded 2^IMEM_AW words

Function
REQ-008 SHALL implement states IDLE, FILL, LOAD, HOLD, RUN, DONE.
REQ-009 IDLE: cpu_rst=1, s_ready=0; start=1 -> FILL next cycle; otherwise stay.
REQ-010 FILL: one dmem write per cycle, addresses 0..2^DMEM_AW-1 ascending, data = address zero-extended (FILL_MODE=1) or 0 (FILL_MODE=0); after the last address -> LOAD.
REQ-011 LOAD: s_ready=1; a beat is accepted when s_valid and s_ready are both 1; s_valid without s_ready is not consumed.
REQ-012 Each accepted beat SHALL be written to imem exactly one cycle later (registered write port) at the current word counter, starting at 0, counter +1 per beat.
REQ-013 Accepted beat with s_last=1 -> HOLD; s_ready=0 from the following cycle.
REQ-014 Accepted beat at counter 2^IMEM_AW-1 with s_last=0: word written, overflow set to 1, -> HOLD; further words are not accepted; no address wrap-around.
REQ-015 HOLD: cpu_rst=1 for exactly RST_HOLD cycles, then -> RUN; cpu_rst falls on the first RUN cycle.
REQ-016 RUN: cpu_rst=0, cycle counter counts from 0; after RUN_CYCLES cycles -> DONE; RUN_CYCLES=0 stays in RUN indefinitely.
REQ-017 DONE: cpu_rst=1 (pipeline frozen), done=1; start=1 -> FILL, clearing done and overflow; otherwise stay.
REQ-018 start SHALL be ignored in FILL, LOAD, HOLD, RUN.
REQ-019 imem_we and dmem_we SHALL never be asserted in the same cycle.
REQ-020 Single-word program (s_last on first beat) SHALL load one word at address 0 and proceed normally.

Reset
REQ-021 rst=0 sampled on a rising edge SHALL force IDLE, all counters 0, imem_we=0, dmem_we=0, s_ready=0, cpu_rst=1, busy=0, done=0, overflow=0, from any state including mid-FILL or mid-LOAD.
REQ-022 Memory contents already written before a mid-operation reset SHALL be left as written; a subsequent start re-runs the full sequence.

Structure
REQ-023 State encoding and FILL_MODE constants SHALL live in a shared package, pipeline_pkg, alongside the opcode/funct constants (R_TYPE, LOAD_WORD, STORE_WORD, BRANCH_EQ, JUMP, AND, OR, ADD, SUB, SLT, NOR).
REQ-024 No sub-module; the FSM, word counter and cycle counter SHALL reside in pipeline_loader, with write ports connecting directly to the pipeline's inst_mem and data_mem.

Verification
REQ-025 Defaults, start pulse -> dmem writes at addresses 0..63 with data 0..63 over 64 consecutive cycles, then s_ready=1.
REQ-026 Stream 4 words (LW r1,0(r31); LW r2,0(r31); ADD r3,r1,r2; SW r3,0(r0)) with s_last on word 4 -> imem[0..3] written in order, cpu_rst low 2 cycles after last beat, 10 RUN cycles, then done=1 and dmem[0]=62.
REQ-027 Stream 65 words with s_last never asserted -> imem[0..63] written, overflow=1, 65th word not accepted (s_ready=0).
REQ-028 Toggle s_valid every other cycle during LOAD -> only beats with s_valid=1 written, addresses contiguous, no gaps.
REQ-029 rst=0 asserted during LOAD after 2 beats -> next cycle IDLE, cpu_rst=1, s_ready=0, counters 0; new start restarts at FILL address 0.
REQ-030 RUN_CYCLES=0 -> remains in RUN with cpu_rst=0 for 100 cycles, done=0.
